// File: rtl/mem_port_arb.sv
// Two-requester arbiter in front of one 24/48-bit memory port, with read-response routing
// and bound checking. Optional starvation guard for R1 is enabled by defining MEM_ARB_STARVE_EN.
module mem_port_arb #(
    parameter int unsigned RR_EN_DEFAULT = 0,
    parameter int unsigned STARVE_MAX    = 15,
    parameter int unsigned ADDR_WORDS    = 4096
) (
    input  logic             iw_clk,
    input  logic             iw_rst,
    input  logic [1:0]       iw_rq_valid,
    output logic [1:0]       ow_rq_ready,
    input  logic [1:0]       iw_rq_we,
    input  logic [1:0][47:0] iw_rq_addr,
    input  logic [1:0][47:0] iw_rq_wdata,
    input  logic [1:0]       iw_rq_is48,
    output logic [1:0]       or_rs_valid,
    output logic [1:0][47:0] ow_rs_rdata,
    output logic [1:0]       or_rs_err,
    output logic             ow_mem_we,
    output logic [47:0]      ow_mem_addr,
    output logic [47:0]      ow_mem_wdata,
    output logic             ow_mem_is48,
    input  logic [47:0]      iw_mem_rdata
);

    localparam logic [47:0] AddrLimit = 48'(ADDR_WORDS);
    localparam logic [47:0] LastWord  = 48'(ADDR_WORDS - 1);

    logic [1:0] gnt;
    logic       conflict;
    logic       sel;
    logic       granted;
    logic       in_range;
    logic       starve_force;

    logic       rd_vld_q, rd_vld_d;
    logic       rd_own_q, rd_own_d;
    logic       rd_is48_q, rd_is48_d;
    logic [1:0] err_q, err_d;
    logic       rr_q, rr_d;

    assign conflict = iw_rq_valid[0] & iw_rq_valid[1];

    // rr_q names the side that wins the next conflict; it is ignored in fixed-priority mode.
    always_comb begin
        gnt = 2'b00;
        if (!iw_rst) begin
            if (conflict) begin
                if (starve_force) begin
                    gnt = 2'b10;
                end else if (RR_EN_DEFAULT != 0 && rr_q) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end else begin
                gnt = iw_rq_valid;
            end
        end
    end

    assign granted     = |gnt;
    assign sel         = gnt[1];
    assign ow_rq_ready = gnt;

    assign in_range = !((iw_rq_addr[sel] >= AddrLimit) ||
                        (iw_rq_is48[sel] && (iw_rq_addr[sel] == LastWord)));

    assign ow_mem_addr  = iw_rq_addr[sel];
    assign ow_mem_wdata = iw_rq_wdata[sel];
    assign ow_mem_we    = granted & iw_rq_we[sel] & in_range;
    assign ow_mem_is48  = granted & iw_rq_is48[sel];

    always_comb begin
        rd_vld_d  = granted & ~iw_rq_we[sel] & in_range;
        rd_own_d  = sel;
        rd_is48_d = iw_rq_is48[sel];
        err_d     = (granted && !in_range) ? gnt : 2'b00;
        rr_d      = (conflict && granted) ? ~sel : rr_q;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            rd_vld_q  <= 1'b0;
            rd_own_q  <= 1'b0;
            rd_is48_q <= 1'b0;
            err_q     <= 2'b00;
            rr_q      <= 1'b0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_own_q  <= rd_own_d;
            rd_is48_q <= rd_is48_d;
            err_q     <= err_d;
            rr_q      <= rr_d;
        end
    end

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starve_q, starve_d;

    // Once the count has sat at the threshold for a denied cycle, R1 takes the next conflict.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;
        if (!iw_rq_valid[1] || gnt[1]) begin
            starve_cnt_d = 4'd0;
            starve_d     = 1'b0;
        end else if (starve_cnt_q == StarveMax) begin
            starve_d = 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            starve_cnt_q <= 4'd0;
            starve_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign starve_force = starve_q;
`else
    assign starve_force = 1'b0;
`endif

    // Responses are masked while reset is asserted so an in-flight read is dropped at once.
    logic [47:0] rd_data;
    assign rd_data = rd_is48_q ? iw_mem_rdata : {24'd0, iw_mem_rdata[23:0]};

    always_comb begin
        or_rs_valid = 2'b00;
        if (rd_vld_q && !iw_rst) begin
            or_rs_valid = rd_own_q ? 2'b10 : 2'b01;
        end
        ow_rs_rdata[0] = or_rs_valid[0] ? rd_data : 48'd0;
        ow_rs_rdata[1] = or_rs_valid[1] ? rd_data : 48'd0;
        or_rs_err      = iw_rst ? 2'b00 : err_q;
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a fixed-priority and a round-robin instance share one stimulus
// stream; each gets its own memory model and is checked every cycle against a reference.
module tb_mem_port_arb;

    localparam int STARVE_MAX = 15;
`ifdef MEM_ARB_STARVE_EN
    localparam bit StarveEn = 1'b1;
`else
    localparam bit StarveEn = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       rq_valid, rq_we, rq_is48;
    logic [1:0][47:0] rq_addr, rq_wdata;

    logic [1:0]       rdy       [2];
    logic [1:0]       rs_valid  [2];
    logic [1:0][47:0] rs_rdata  [2];
    logic [1:0]       rs_err    [2];
    logic             mem_we    [2];
    logic [47:0]      mem_addr  [2];
    logic [47:0]      mem_wdata [2];
    logic             mem_is48  [2];
    logic [47:0]      mem_rdata [2];

    int tests = 0;
    int fails = 0;

    mem_port_arb #(.RR_EN_DEFAULT(0), .STARVE_MAX(STARVE_MAX), .ADDR_WORDS(4096)) u_fix (
        .iw_clk(clk), .iw_rst(rst),
        .iw_rq_valid(rq_valid), .ow_rq_ready(rdy[0]), .iw_rq_we(rq_we),
        .iw_rq_addr(rq_addr), .iw_rq_wdata(rq_wdata), .iw_rq_is48(rq_is48),
        .or_rs_valid(rs_valid[0]), .ow_rs_rdata(rs_rdata[0]), .or_rs_err(rs_err[0]),
        .ow_mem_we(mem_we[0]), .ow_mem_addr(mem_addr[0]), .ow_mem_wdata(mem_wdata[0]),
        .ow_mem_is48(mem_is48[0]), .iw_mem_rdata(mem_rdata[0])
    );

    mem_port_arb #(.RR_EN_DEFAULT(1), .STARVE_MAX(STARVE_MAX), .ADDR_WORDS(4096)) u_rr (
        .iw_clk(clk), .iw_rst(rst),
        .iw_rq_valid(rq_valid), .ow_rq_ready(rdy[1]), .iw_rq_we(rq_we),
        .iw_rq_addr(rq_addr), .iw_rq_wdata(rq_wdata), .iw_rq_is48(rq_is48),
        .or_rs_valid(rs_valid[1]), .ow_rs_rdata(rs_rdata[1]), .or_rs_err(rs_err[1]),
        .ow_mem_we(mem_we[1]), .ow_mem_addr(mem_addr[1]), .ow_mem_wdata(mem_wdata[1]),
        .ow_mem_is48(mem_is48[1]), .iw_mem_rdata(mem_rdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Memory seen by each DUT: keyed by instance*8192+addr, unwritten words read as 0.
    logic [23:0] emem [int];

    function automatic logic [23:0] eget(input int k);
        if (emem.exists(k)) return emem[k];
        return 24'd0;
    endfunction

    initial begin
        for (int g = 0; g < 2; g++) mem_rdata[g] = 48'd0;
        forever begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) begin
                int a;
                logic [23:0] lo, hi;
                a  = (mem_addr[g] < 48'd4096) ? int'(mem_addr[g]) : -1;
                lo = (a >= 0) ? eget(g * 8192 + a) : 24'd0;
                hi = (a >= 0 && a < 4095) ? eget(g * 8192 + a + 1) : 24'd0;
                mem_rdata[g] = mem_is48[g] ? {hi, lo} : {24'd0, lo};
                if (mem_we[g] && a >= 0) begin
                    emem[g * 8192 + a] = mem_wdata[g][23:0];
                    if (mem_is48[g] && a < 4095) emem[g * 8192 + a + 1] = mem_wdata[g][47:24];
                end
            end
        end
    end

    // Reference model: transaction-level state per instance.
    logic [23:0] rmem [int];
    bit          rr_side   [2];
    int          streak    [2];
    bit          pend_rd   [2];
    bit          pend_err  [2];
    int          pend_side [2];
    logic [47:0] pend_data [2];

    function automatic logic [23:0] rget(input int k);
        if (rmem.exists(k)) return rmem[k];
        return 24'd0;
    endfunction

    task automatic model_step(input int m);
        bit gr, ok;
        int win, a;
        logic [1:0] exp_rdy;
        logic [47:0] addr;
        gr  = 1'b0;
        win = 0;
        if (!rst && rq_valid != 2'b00) begin
            gr = 1'b1;
            if (rq_valid == 2'b11) begin
                if (StarveEn && streak[m] > STARVE_MAX) win = 1;
                else if (m == 1) win = int'(rr_side[m]);
                else win = 0;
            end else begin
                win = rq_valid[1] ? 1 : 0;
            end
        end
        addr    = rq_addr[win];
        ok      = (addr < 48'd4096) && !(rq_is48[win] && addr == 48'd4095);
        a       = ok ? int'(addr) : 0;
        exp_rdy = gr ? (win == 1 ? 2'b10 : 2'b01) : 2'b00;

        chk($sformatf("m%0d ready", m), 48'(rdy[m]), 48'(exp_rdy));
        chk($sformatf("m%0d mem_we", m), 48'(mem_we[m]), 48'(gr && rq_we[win] && ok));
        chk($sformatf("m%0d mem_is48", m), 48'(mem_is48[m]), 48'(gr && rq_is48[win]));
        if (gr) begin
            chk($sformatf("m%0d mem_addr", m), mem_addr[m], addr);
            chk($sformatf("m%0d mem_wdata", m), mem_wdata[m], rq_wdata[win]);
        end
        for (int s = 0; s < 2; s++) begin
            bit ev, ee;
            ev = !rst && pend_rd[m] && pend_side[m] == s;
            ee = !rst && pend_err[m] && pend_side[m] == s;
            chk($sformatf("m%0d rs_valid[%0d]", m, s), 48'(rs_valid[m][s]), 48'(ev));
            chk($sformatf("m%0d rs_err[%0d]", m, s), 48'(rs_err[m][s]), 48'(ee));
            chk($sformatf("m%0d rs_rdata[%0d]", m, s), rs_rdata[m][s], ev ? pend_data[m] : 48'd0);
        end

        if (rst) begin
            rr_side[m]  = 1'b0;
            streak[m]   = 0;
            pend_rd[m]  = 1'b0;
            pend_err[m] = 1'b0;
        end else begin
            pend_rd[m]   = gr && !rq_we[win] && ok;
            pend_err[m]  = gr && !ok;
            pend_side[m] = win;
            pend_data[m] = rq_is48[win] ? {rget(m * 8192 + a + 1), rget(m * 8192 + a)}
                                        : {24'd0, rget(m * 8192 + a)};
            if (gr && rq_we[win] && ok) begin
                rmem[m * 8192 + a] = rq_wdata[win][23:0];
                if (rq_is48[win]) rmem[m * 8192 + a + 1] = rq_wdata[win][47:24];
            end
            if (rq_valid == 2'b11) rr_side[m] = (win == 0);
            streak[m] = (rq_valid[1] && !(gr && win == 1)) ? streak[m] + 1 : 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step(0);
            model_step(1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int s, input logic we, input logic [47:0] a,
                          input logic [47:0] d, input logic is48);
        rq_valid[s] = 1'b1;
        rq_we[s]    = we;
        rq_addr[s]  = a;
        rq_wdata[s] = d;
        rq_is48[s]  = is48;
    endtask

    task automatic clr_rq(input int s);
        rq_valid[s] = 1'b0;
        rq_we[s]    = 1'b0;
        rq_is48[s]  = 1'b0;
    endtask

    initial begin
        int first_r1, n_r1_fix, n_r1_rr;
        logic [4:0] pat_fix, pat_rr;
        rst      = 1'b1;
        rq_valid = 2'b00;
        rq_we    = 2'b00;
        rq_is48  = 2'b00;
        rq_addr  = '0;
        rq_wdata = '0;
        step();
        @(negedge clk);
        chk("reset rs_valid", 48'({rs_valid[0], rs_valid[1]}), 48'd0);
        chk("reset mem_we", 48'({mem_we[0], mem_we[1]}), 48'd0);
        step();
        rst = 1'b0;

        // R0 only: 48-bit write, 48-bit read, 24-bit read of the upper word
        set_rq(0, 1'b1, 48'd10, 48'h000002_000001, 1'b1);
        @(negedge clk);
        chk("t1 wr ready", 48'(rdy[0]), 48'(2'b01));
        chk("t1 wr mem_we", 48'(mem_we[0]), 48'd1);
        step();
        set_rq(0, 1'b0, 48'd10, 48'd0, 1'b1);
        @(negedge clk);
        step();
        set_rq(0, 1'b0, 48'd11, 48'd0, 1'b0);
        @(negedge clk);
        chk("t1 rd48 valid", 48'(rs_valid[0]), 48'(2'b01));
        chk("t1 rd48 data", rs_rdata[0][0], 48'h000002_000001);
        step();
        clr_rq(0);
        @(negedge clk);
        chk("t1 rd24 data", rs_rdata[1][0], 48'h000000_000002);
        step();

        // Conflict for five cycles
        set_rq(0, 1'b0, 48'd10, 48'd0, 1'b0);
        set_rq(1, 1'b0, 48'd11, 48'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pat_fix[k] = rdy[0][1];
            pat_rr[k]  = rdy[1][1];
            step();
        end
        clr_rq(0);
        clr_rq(1);
        chk("t2 fixed grants", 48'(pat_fix), 48'(5'b00000));
        chk("t2 rr grants", 48'(pat_rr), 48'(5'b01010));
        step();

        // R1 writes, R0 reads the same word the next cycle
        set_rq(1, 1'b1, 48'd20, 48'h000000_ABCDEF, 1'b0);
        @(negedge clk);
        step();
        clr_rq(1);
        set_rq(0, 1'b0, 48'd20, 48'd0, 1'b0);
        @(negedge clk);
        step();
        clr_rq(0);
        @(negedge clk);
        chk("t3 fwd valid", 48'(rs_valid[1]), 48'(2'b01));
        chk("t3 fwd data", rs_rdata[0][0], 48'h000000_ABCDEF);
        step();

        // Bounds
        set_rq(1, 1'b1, 48'd4095, 48'h111111_222222, 1'b1);
        @(negedge clk);
        chk("t4 oob ready", 48'(rdy[0]), 48'(2'b10));
        chk("t4 oob mem_we", 48'(mem_we[0]), 48'd0);
        step();
        clr_rq(1);
        set_rq(0, 1'b0, 48'd4096, 48'd0, 1'b0);
        @(negedge clk);
        chk("t4 wr err", 48'(rs_err[0]), 48'(2'b10));
        step();
        set_rq(0, 1'b1, 48'd4095, 48'h000000_777777, 1'b0);
        @(negedge clk);
        chk("t4 rd err", 48'(rs_err[0]), 48'(2'b01));
        chk("t4 rd no valid", 48'(rs_valid[0]), 48'd0);
        chk("t4 last word we", 48'(mem_we[0]), 48'd1);
        step();
        set_rq(0, 1'b0, 48'd4095, 48'd0, 1'b0);
        @(negedge clk);
        step();
        clr_rq(0);
        @(negedge clk);
        chk("t4 last word data", rs_rdata[0][0], 48'h000000_777777);
        step();

        // Reset lands while a read is in flight
        set_rq(0, 1'b0, 48'd10, 48'd0, 1'b0);
        @(negedge clk);
        step();
        rst = 1'b1;
        set_rq(0, 1'b1, 48'd30, 48'h000000_5A5A5A, 1'b0);
        @(negedge clk);
        chk("t5 rst rs_valid", 48'(rs_valid[0]), 48'd0);
        chk("t5 rst ready", 48'(rdy[0]), 48'd0);
        chk("t5 rst mem_we", 48'(mem_we[0]), 48'd0);
        step();
        @(negedge clk);
        chk("t5 rst rs_valid2", 48'(rs_valid[0]), 48'd0);
        step();
        rst = 1'b0;
        set_rq(0, 1'b0, 48'd30, 48'd0, 1'b0);
        @(negedge clk);
        step();
        clr_rq(0);
        @(negedge clk);
        chk("t5 suppressed wr", rs_rdata[0][0], 48'd0);
        step();

        // Continuous conflict from a clean reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_rq(0, 1'b0, 48'd100, 48'd0, 1'b0);
        set_rq(1, 1'b0, 48'd200, 48'd0, 1'b0);
        first_r1 = 0;
        n_r1_fix = 0;
        n_r1_rr  = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (rdy[0][1]) begin
                n_r1_fix++;
                if (first_r1 == 0) first_r1 = k;
            end
            if (rdy[1][1]) n_r1_rr++;
            step();
        end
        clr_rq(0);
        clr_rq(1);
        chk("t6 first R1 grant", 48'(first_r1), StarveEn ? 48'd17 : 48'd0);
        chk("t6 R1 grants fixed", 48'(n_r1_fix), StarveEn ? 48'd1 : 48'd0);
        chk("t6 R1 grants rr", 48'(n_r1_rr), 48'd16);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
